// File: rtl/cache_pkg.sv
// Shared types and default geometry for the 2-way write-back cache.
package cache_pkg;
  localparam int DEF_TAG_W    = 3;
  localparam int DEF_INDEX_W  = 2;
  localparam int DEF_OFFSET_W = 1;
  localparam int DEF_WORD_W   = 32;

  localparam int BLK_W   = DEF_WORD_W << DEF_OFFSET_W;
  localparam int BADDR_W = DEF_TAG_W + DEF_INDEX_W;
  localparam int WAYS    = 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} stateT;
endpackage

// File: rtl/assoc_wb_cache_if.sv
// Processor request/stall and memory block request/done signals of the cache.
interface assoc_wb_cache_if #(
  parameter int TAG_W    = cache_pkg::DEF_TAG_W,
  parameter int INDEX_W  = cache_pkg::DEF_INDEX_W,
  parameter int OFFSET_W = cache_pkg::DEF_OFFSET_W,
  parameter int WORD_W   = cache_pkg::DEF_WORD_W
);
  localparam int BLK_W   = WORD_W << OFFSET_W;
  localparam int BADDR_W = TAG_W + INDEX_W;

  logic                readRequest;
  logic                writeRequest;
  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  index;
  logic [OFFSET_W-1:0] offset;
  logic [WORD_W-1:0]   dataFromProg;
  logic [WORD_W-1:0]   dataOut;
  logic                hit;
  logic                stall;
  logic                memRead;
  logic                memWrite;
  logic [BADDR_W-1:0]  memAddr;
  logic [BLK_W-1:0]    memWData;
  logic [BLK_W-1:0]    memRData;
  logic                memDone;

  modport slave (
    input  readRequest, writeRequest, tag, index, offset, dataFromProg, memRData, memDone,
    output dataOut, hit, stall, memRead, memWrite, memAddr, memWData
  );

  modport master (
    output readRequest, writeRequest, tag, index, offset, dataFromProg, memRData, memDone,
    input  dataOut, hit, stall, memRead, memWrite, memAddr, memWData
  );
endinterface

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid/dirty/tag/block storage and tag compare.
module cache_way_array #(
  parameter int TAG_W    = cache_pkg::DEF_TAG_W,
  parameter int INDEX_W  = cache_pkg::DEF_INDEX_W,
  parameter int OFFSET_W = cache_pkg::DEF_OFFSET_W,
  parameter int WORD_W   = cache_pkg::DEF_WORD_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INDEX_W-1:0]           index,
  input  logic [TAG_W-1:0]             lookupTag,
  output logic                         matchHit,
  output logic                         lineValid,
  output logic                         lineDirty,
  output logic [TAG_W-1:0]             lineTag,
  output logic [(WORD_W<<OFFSET_W)-1:0] lineBlock,
  input  logic                         fillEn,
  input  logic [TAG_W-1:0]             fillTag,
  input  logic [(WORD_W<<OFFSET_W)-1:0] fillBlock,
  input  logic                         wordWrEn,
  input  logic [OFFSET_W-1:0]          wordOffset,
  input  logic [WORD_W-1:0]            wordData,
  input  logic                         cleanEn
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int BLK_W = WORD_W << OFFSET_W;

  logic [SETS-1:0]  validReg;
  logic [SETS-1:0]  dirtyReg;
  logic [TAG_W-1:0] tagMem   [SETS];
  logic [BLK_W-1:0] blockMem [SETS];

  assign lineValid = validReg[index];
  assign lineDirty = dirtyReg[index];
  assign lineTag   = tagMem[index];
  assign lineBlock = blockMem[index];
  assign matchHit  = lineValid && (tagMem[index] == lookupTag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      validReg <= '0;
      dirtyReg <= '0;
    end else if (fillEn) begin
      validReg[index] <= 1'b1;
      dirtyReg[index] <= 1'b0;
    end else if (wordWrEn) begin
      dirtyReg[index] <= 1'b1;
    end else if (cleanEn) begin
      dirtyReg[index] <= 1'b0;
    end
  end

  // Tag/data contents are deliberately left unreset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fillEn) begin
      tagMem[index]   <= fillTag;
      blockMem[index] <= fillBlock;
    end else if (wordWrEn) begin
      blockMem[index][wordOffset*WORD_W +: WORD_W] <= wordData;
    end
  end
endmodule

// File: rtl/assoc_wb_cache.sv
// 2-way set-associative write-back/write-allocate cache: lookup, LRU and miss FSM.
module assoc_wb_cache import cache_pkg::*; #(
  parameter int TAG_W    = DEF_TAG_W,
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int OFFSET_W = DEF_OFFSET_W,
  parameter int WORD_W   = DEF_WORD_W
) (
  input logic              clk,
  input logic              reset,
  assoc_wb_cache_if.slave  bus
);
  localparam int SETS    = 1 << INDEX_W;
  localparam int BLK_W   = WORD_W << OFFSET_W;
  localparam int BADDR_W = TAG_W + INDEX_W;

  stateT              stateReg, stateNext;
  logic [SETS-1:0]    lruReg;
  logic               victimReg, victimNext;
  logic [TAG_W-1:0]   tagReg;
  logic [INDEX_W-1:0] indexReg;
  logic               latchEn, lruWrEn;

  logic [INDEX_W-1:0] curIndex;
  logic [WAYS-1:0]    wayMatch, wayValid, wayDirty;
  logic [WAYS-1:0]    wayFill, wayWordWr, wayClean;
  logic [TAG_W-1:0]   wayTag   [WAYS];
  logic [BLK_W-1:0]   wayBlock [WAYS];

  logic               request, anyHit, hitWay, victimPick;
  logic [BLK_W-1:0]   hitBlock;
  logic [WORD_W-1:0]  hitWord;

  logic               hitC, stallC, memReadC, memWriteC;
  logic [WORD_W-1:0]  dataOutC;
  logic [BADDR_W-1:0] memAddrC;
  logic [BLK_W-1:0]   memWDataC;

  // Outside IDLE the arrays are addressed by the index captured at the miss.
  assign curIndex = (stateReg == IDLE) ? bus.index : indexReg;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : gWay
      cache_way_array #(
        .TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .WORD_W(WORD_W)
      ) uWay (
        .clk(clk), .reset(reset),
        .index(curIndex), .lookupTag(bus.tag),
        .matchHit(wayMatch[gi]), .lineValid(wayValid[gi]), .lineDirty(wayDirty[gi]),
        .lineTag(wayTag[gi]), .lineBlock(wayBlock[gi]),
        .fillEn(wayFill[gi]), .fillTag(tagReg), .fillBlock(bus.memRData),
        .wordWrEn(wayWordWr[gi]), .wordOffset(bus.offset), .wordData(bus.dataFromProg),
        .cleanEn(wayClean[gi])
      );
    end
  endgenerate

  assign request    = bus.readRequest || bus.writeRequest;
  assign anyHit     = |wayMatch;
  assign hitWay     = !wayMatch[0];
  assign hitBlock   = wayBlock[hitWay];
  assign hitWord    = hitBlock[bus.offset*WORD_W +: WORD_W];
  assign victimPick = !wayValid[0] ? 1'b0 : (!wayValid[1] ? 1'b1 : lruReg[curIndex]);

  always_comb begin
    stateNext  = stateReg;
    victimNext = victimReg;
    latchEn    = 1'b0;
    lruWrEn    = 1'b0;
    wayFill    = '0;
    wayWordWr  = '0;
    wayClean   = '0;
    hitC       = 1'b0;
    stallC     = 1'b0;
    memReadC   = 1'b0;
    memWriteC  = 1'b0;
    dataOutC   = '0;
    memAddrC   = '0;
    memWDataC  = '0;
    case (stateReg)
      IDLE: begin
        if (request && anyHit) begin
          hitC    = 1'b1;
          lruWrEn = 1'b1;
          if (bus.writeRequest) wayWordWr[hitWay] = 1'b1;
          else                  dataOutC = hitWord;
        end else if (request) begin
          stallC     = 1'b1;
          latchEn    = 1'b1;
          victimNext = victimPick;
          stateNext  = (wayValid[victimPick] && wayDirty[victimPick]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        stallC    = 1'b1;
        memWriteC = 1'b1;
        memAddrC  = {wayTag[victimReg], indexReg};
        memWDataC = wayBlock[victimReg];
        if (bus.memDone) begin
          wayClean[victimReg] = 1'b1;
          stateNext           = REFILL;
        end
      end
      REFILL: begin
        stallC   = 1'b1;
        memReadC = 1'b1;
        memAddrC = {tagReg, indexReg};
        if (bus.memDone) begin
          wayFill[victimReg] = 1'b1;
          stateNext          = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    // Reset silences the outputs at once, even with a request still held.
    if (reset) begin
      wayFill   = '0;
      wayWordWr = '0;
      wayClean  = '0;
      hitC      = 1'b0;
      stallC    = 1'b0;
      memReadC  = 1'b0;
      memWriteC = 1'b0;
      dataOutC  = '0;
      memAddrC  = '0;
      memWDataC = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg  <= IDLE;
      lruReg    <= '0;
      victimReg <= 1'b0;
      tagReg    <= '0;
      indexReg  <= '0;
    end else begin
      stateReg  <= stateNext;
      victimReg <= victimNext;
      if (latchEn) begin
        tagReg   <= bus.tag;
        indexReg <= bus.index;
      end
      if (lruWrEn) lruReg[curIndex] <= ~hitWay;
    end
  end

  assign bus.hit      = hitC;
  assign bus.stall    = stallC;
  assign bus.memRead  = memReadC;
  assign bus.memWrite = memWriteC;
  assign bus.dataOut  = dataOutC;
  assign bus.memAddr  = memAddrC;
  assign bus.memWData = memWDataC;
endmodule

// File: tb/tb_assoc_wb_cache.sv
// Directed bench for assoc_wb_cache: hit vectors from a table, misses as sequences.
module tb_assoc_wb_cache;
  localparam int BLK_W   = cache_pkg::BLK_W;
  localparam int BADDR_W = cache_pkg::BADDR_W;

  logic clk;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  assoc_wb_cache_if bus ();

  assoc_wb_cache dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        wr;
    logic [2:0]  tg;
    logic [1:0]  ix;
    logic        ox;
    logic [31:0] wd;
    logic [31:0] expData;
  } vecT;

  vecT vecs [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passes++;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] tg,
                       input logic [1:0] ix, input logic ox, input logic [31:0] wd);
    bus.readRequest  = rd;
    bus.writeRequest = wr;
    bus.tag          = tg;
    bus.index        = ix;
    bus.offset       = ox;
    bus.dataFromProg = wd;
  endtask

  // Every table entry is expected to be serviced as a zero-wait hit.
  task automatic runVecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(!vecs[i].wr, vecs[i].wr, vecs[i].tg, vecs[i].ix, vecs[i].ox, vecs[i].wd);
      @(negedge clk);
      chk({vecs[i].nm, " hit"}, 64'(bus.hit), 64'd1);
      chk({vecs[i].nm, " stall"}, 64'(bus.stall), 64'd0);
      chk({vecs[i].nm, " memtraffic"}, 64'({bus.memRead, bus.memWrite}), 64'd0);
      chk({vecs[i].nm, " dataOut"}, 64'(bus.dataOut), 64'(vecs[i].expData));
      $display("txn %s: tag=%0d idx=%0d off=%0d wr=%b dataOut=%h", vecs[i].nm,
               vecs[i].tg, vecs[i].ix, vecs[i].ox, vecs[i].wr, bus.dataOut);
      nextCycle();
    end
  endtask

  // Request must already be driven; returns at the negedge of the post-fill cycle.
  task automatic missSeq(input string nm, input logic expWb, input logic [BADDR_W-1:0] wbAddr,
                         input logic [BLK_W-1:0] wbData, input logic [BADDR_W-1:0] rdAddr,
                         input logic [BLK_W-1:0] fillData);
    @(negedge clk);
    chk({nm, " miss stall"}, 64'(bus.stall), 64'd1);
    chk({nm, " miss hit"}, 64'(bus.hit), 64'd0);
    chk({nm, " miss memRead"}, 64'(bus.memRead), 64'd0);
    nextCycle();
    if (expWb) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk({nm, " wb memWrite"}, 64'(bus.memWrite), 64'd1);
        chk({nm, " wb memRead"}, 64'(bus.memRead), 64'd0);
        chk({nm, " wb memAddr"}, 64'(bus.memAddr), 64'(wbAddr));
        chk({nm, " wb memWData"}, 64'(bus.memWData), 64'(wbData));
        if (k == 1) bus.memDone = 1'b1;
        nextCycle();
      end
      bus.memDone = 1'b0;
    end
    @(negedge clk);
    chk({nm, " refill memRead"}, 64'(bus.memRead), 64'd1);
    chk({nm, " refill memWrite"}, 64'(bus.memWrite), 64'd0);
    chk({nm, " refill memAddr"}, 64'(bus.memAddr), 64'(rdAddr));
    chk({nm, " refill stall"}, 64'(bus.stall), 64'd1);
    bus.memRData = fillData;
    bus.memDone  = 1'b1;
    nextCycle();
    bus.memDone = 1'b0;
    @(negedge clk);
    $display("txn %s: miss serviced memAddr=%h", nm, rdAddr);
  endtask

  initial begin
    vecs[0]  = '{"rd t0 o1",       1'b0, 3'd0, 2'd0, 1'b1, 32'h0,        32'hFFFFAAAA};
    vecs[1]  = '{"wr t0 o1",       1'b1, 3'd0, 2'd0, 1'b1, 32'h12345678, 32'h0};
    vecs[2]  = '{"rdback t0 o1",   1'b0, 3'd0, 2'd0, 1'b1, 32'h0,        32'h12345678};
    vecs[3]  = '{"rd t0 o0",       1'b0, 3'd0, 2'd0, 1'b0, 32'h0,        32'hAAAAFFFF};
    vecs[4]  = '{"rd t1 o1",       1'b0, 3'd1, 2'd0, 1'b1, 32'h0,        32'h22222222};
    vecs[5]  = '{"rd t1 o0 post",  1'b0, 3'd1, 2'd0, 1'b0, 32'h0,        32'h11111111};
    vecs[6]  = '{"rd t2 o1",       1'b0, 3'd2, 2'd0, 1'b1, 32'h0,        32'h44444444};
    vecs[7]  = '{"rd t3 i1 o0",    1'b0, 3'd3, 2'd1, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{"rd t3 i1 o1",    1'b0, 3'd3, 2'd1, 1'b1, 32'h0,        32'h66666666};

    drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
    bus.memRData = '0;
    bus.memDone  = 1'b0;
    reset        = 1'b1;

    // Reset state
    repeat (3) nextCycle();
    @(negedge clk);
    chk("reset hit", 64'(bus.hit), 64'd0);
    chk("reset stall", 64'(bus.stall), 64'd0);
    chk("reset memRead/memWrite", 64'({bus.memRead, bus.memWrite}), 64'd0);
    chk("reset dataOut", 64'(bus.dataOut), 64'd0);
    chk("reset memAddr", 64'(bus.memAddr), 64'd0);
    chk("reset memWData", 64'(bus.memWData), 64'd0);
    #2 reset = 1'b0;
    nextCycle();

    // Cold read miss, refill, then hits in the same block and a write hit
    drive(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
    missSeq("cold", 1'b0, 5'b00000, 64'h0, 5'b00000, 64'hFFFFAAAA_AAAAFFFF);
    chk("cold hit", 64'(bus.hit), 64'd1);
    chk("cold dataOut", 64'(bus.dataOut), 64'hAAAAFFFF);
    nextCycle();
    runVecs(0, 2);

    // Second way fills without write-back; both ways then hit (LRU ends on way0)
    drive(1'b1, 1'b0, 3'd1, 2'd0, 1'b0, 32'h0);
    missSeq("way1", 1'b0, 5'b00000, 64'h0, 5'b00100, 64'h22222222_11111111);
    chk("way1 hit", 64'(bus.hit), 64'd1);
    chk("way1 dataOut", 64'(bus.dataOut), 64'h11111111);
    nextCycle();
    runVecs(3, 4);

    // Dirty eviction of way0 followed by refill
    drive(1'b1, 1'b0, 3'd2, 2'd0, 1'b0, 32'h0);
    missSeq("evict", 1'b1, 5'b00000, 64'h12345678_AAAAFFFF, 5'b01000, 64'h44444444_33333333);
    chk("evict hit", 64'(bus.hit), 64'd1);
    chk("evict dataOut", 64'(bus.dataOut), 64'h33333333);
    nextCycle();
    runVecs(5, 6);

    // memDone while idle must be ignored
    drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
    bus.memDone = 1'b1;
    @(negedge clk);
    chk("idle memDone stall", 64'(bus.stall), 64'd0);
    chk("idle memDone memRead", 64'(bus.memRead), 64'd0);
    nextCycle();
    bus.memDone = 1'b0;
    @(negedge clk);
    chk("idle after memDone stall", 64'(bus.stall), 64'd0);
    nextCycle();

    // Write miss allocates, then merges the store on the post-fill hit
    drive(1'b0, 1'b1, 3'd3, 2'd1, 1'b0, 32'hDEADBEEF);
    missSeq("wrmiss", 1'b0, 5'b00000, 64'h0, 5'b01101, 64'h66666666_55555555);
    chk("wrmiss hit", 64'(bus.hit), 64'd1);
    chk("wrmiss dataOut", 64'(bus.dataOut), 64'd0);
    nextCycle();
    runVecs(7, 8);

    // Asynchronous reset in the middle of a refill
    drive(1'b1, 1'b0, 3'd1, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    chk("abort miss stall", 64'(bus.stall), 64'd1);
    nextCycle();
    @(negedge clk);
    chk("abort memRead before", 64'(bus.memRead), 64'd1);
    chk("abort memAddr before", 64'(bus.memAddr), 64'(5'b00110));
    #1 reset = 1'b1;
    #1;
    chk("abort memRead dropped", 64'(bus.memRead), 64'd0);
    chk("abort stall dropped", 64'(bus.stall), 64'd0);
    $display("txn abort: reset asserted mid-refill");
    drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);
    #1 reset = 1'b0;
    nextCycle();
    drive(1'b1, 1'b0, 3'd2, 2'd0, 1'b0, 32'h0);
    @(negedge clk);
    chk("post-reset reread hit", 64'(bus.hit), 64'd0);
    chk("post-reset reread stall", 64'(bus.stall), 64'd1);
    $display("txn reread: tag=2 idx=0 hit=%b stall=%b", bus.hit, bus.stall);
    nextCycle();
    drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
- 2-way set-associative, write-back, write-allocate cache controller. Parametrised successor to the direct-mapped, read-refill-only cache.
- Sits between the processor's load/store stage and the main-memory model.
- Processor side: word-wide request/stall handshake.
- Memory side: block-wide request/done handshake, with dirty-victim write-back before refill.

Parameters:
- TAG_W, 3, tag bits per address
- INDEX_W, 2, set-index bits (sets = 2**INDEX_W)
- OFFSET_W, 1, word-offset bits (words per block = 2**OFFSET_W)
- WORD_W, 32, data word width
- Derived, not overridable: BLK_W = WORD_W << OFFSET_W; BADDR_W = TAG_W + INDEX_W

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  one clock; reset is asynchronous and active-high
- readRequest  in  1  processor read; held until stall low
- writeRequest  in  1  processor write; held until stall low; wins if both asserted
- tag  in  TAG_W  address tag
- index  in  INDEX_W  set index
- offset  in  OFFSET_W  word within block
- dataFromProg  in  WORD_W  store data
- dataOut  out  WORD_W  load data, valid while hit=1
- hit  out  1  request serviced this cycle
- stall  out  1  request pending on memory
- memRead  out  1  block refill request
- memWrite  out  1  block write-back request
- memAddr  out  BADDR_W  block address {tag,index}
- memWData  out  BLK_W  victim block, word 0 in LSBs
- memRData  in  BLK_W  refill block, word 0 in LSBs
- memDone  in  1  one-cycle pulse, completes the current memRead/memWrite

Behaviour:
- Storage: per set per way valid, dirty, tag, block. One LRU bit per set naming the least-recently-used way.
- Reset, asynchronous: all valid/dirty/LRU bits cleared; state IDLE; hit, stall, memRead, memWrite, dataOut, memAddr, memWData all 0. Data arrays not cleared.
- Reset during WRITEBACK or REFILL aborts the transaction; memRead/memWrite drop immediately.
- State machine: IDLE, WRITEBACK, REFILL.
- IDLE, no request: hit=0, stall=0.
- IDLE, request hits (valid && tag match in either way, combinational lookup):
  - hit=1, stall=0 same cycle; dataOut = matched word (0 for a write hit).
  - On the edge, a write updates that word and sets dirty; LRU <- other way.
  - Zero-wait: a held request is serviced every cycle.
- IDLE, request misses:
  - hit=0, stall=1 the same cycle.
  - Victim selection: first invalid way (way0 preferred), else the LRU way.
  - Next state WRITEBACK if victim is valid && dirty, else REFILL.
- WRITEBACK:
  - stall=1, memWrite=1, memAddr={victim tag,index}, memWData=victim block, all held stable.
  - On memDone: victim dirty cleared -> REFILL.
- REFILL:
  - stall=1, memRead=1, memAddr={tag,index}.
  - On memDone: victim way gets memRData, tag, valid=1, dirty=0 -> IDLE.
  - The held request then hits on the next cycle; a pending write merges and sets dirty there.
- memRead and memWrite are never both high.
- Minimum miss latency: clean victim = 1 cycle + memory time; dirty victim = 2 cycles + memory time.
- memDone in IDLE is ignored.
- Request inputs changing while stall=1 are a protocol violation. The address is latched at miss, so the fill uses the latched address.
- Width rules: dataOut word select = block[offset*WORD_W +: WORD_W]. No arithmetic beyond offset scaling.

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, WRITEBACK, REFILL};
  - derived width localparams BLK_W, BADDR_W;
  - WAYS=2 constant.
- One sub-module, cache_way_array: single way's valid/dirty/tag/data storage with lookup compare. Instantiated twice.
- LRU bits and the FSM stay in the top.

Test Plan:
1. Reset for 3 cycles with requests low -> hit=stall=memRead=memWrite=0, dataOut=0.
2. Cold read miss and refill:
   - read tag0 idx0 off0 -> stall=1, memRead=1, memAddr=5'b00000.
   - Return memDone with memRData=64'hFFFFAAAA_AAAAFFFF -> next cycle hit=1, dataOut=32'hAAAAFFFF.
   - Then off1 -> hit, dataOut=32'hFFFFAAAA, no memRead.
3. Write hit: write 32'h12345678 to tag0 idx0 off1 -> hit=1, stall=0; read back off1 -> 32'h12345678, no memory traffic.
4. Second way fill: read tag1 idx0 -> miss, refill into way1, memWrite never asserted; tag0 and tag1 then both hit.
5. Dirty eviction, following scenario 4 (LRU=way0):
   - read tag2 idx0 -> memWrite=1, memAddr=5'b00000, memWData=64'h12345678_AAAAFFFF.
   - After memDone -> memRead=1, memAddr=5'b01000.
   - After memDone -> hit.
6. Async reset while memRead=1 -> memRead and stall fall before next clock edge. Re-read of tag2 idx0 misses, proving valid bits cleared.
